// File: rtl/atriusb_event_readout_mux.sv
// Event readout mux: drains NCHAN FWFT event FIFOs into the FX2 byte stream.
// Round-robin per event, optional channel tag, burst-gated payload.
module atriusb_event_readout_mux #(
    parameter int NCHAN       = 4,
    parameter int CNT_W       = 16,
    parameter int BURST_WORDS = 256,
    parameter int TAG_EN      = 1
) (
    input  logic                   phy_clk_i,
    input  logic                   rst_i,
    input  logic [16*NCHAN-1:0]    src_dat_i,
    input  logic [CNT_W*NCHAN-1:0] src_count_i,
    output logic [NCHAN-1:0]       src_rd_o,
    output logic [7:0]             bridge_dat_o,
    input  logic                   bridge_rd_i,
    input  logic                   event_pause_i,
    output logic                   event_pending_o,
    output logic                   event_done_o,
    output logic [2:0]             chan_o
);

    typedef enum logic [3:0] {
        IDLE,
        POP_HDR,
        POP_NW,
        HDR_OUT,
        CHECK,
        CHK_WAIT,
        SEND_MSB,
        SEND_LSB,
        SEND_POP,
        SEND_LOAD,
        DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       rr_q;
    logic [2:0]       chan_q;
    logic [15:0]      hdr_q;
    logic [15:0]      nw_q;
    logic [15:0]      rem_q;
    logic [15:0]      burst_q;
    logic [15:0]      need_q;
    logic [2:0]       hidx_q;
    logic [NCHAN-1:0] src_rd_q;
    logic [7:0]       dat_q;
    logic             pending_q;
    logic             done_q;

    logic [15:0]      head;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic [2:0]       hit_ch;
    logic [7:0]       tag;
    logic [7:0]       hnext;
    logic             consume;

    assign tag     = {5'b0, chan_q};
    assign consume = bridge_rd_i && pending_q;

    always_comb begin
        head = '0;
        cnt  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (chan_q == 3'(c)) begin
                head = src_dat_i[16*c +: 16];
                cnt  = src_count_i[CNT_W*c +: CNT_W];
            end
        end
    end

    // First channel at or after the rr pointer holding header + nwords.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = 0; i < NCHAN; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= NCHAN) idx = idx - NCHAN;
            if (!hit && src_count_i[CNT_W*idx +: CNT_W] >= CNT_W'(2)) begin
                hit    = 1'b1;
                hit_ch = 3'(idx);
            end
        end
    end

    always_comb begin
        hnext = '0;
        case (hidx_q + 3'd1)
            3'd1:    hnext = hdr_q[15:8];
            3'd2:    hnext = hdr_q[7:0];
            3'd3:    hnext = nw_q[15:8];
            default: hnext = nw_q[7:0];
        endcase
    end

    always_ff @(posedge phy_clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            chan_q    <= '0;
            hdr_q     <= '0;
            nw_q      <= '0;
            rem_q     <= '0;
            burst_q   <= '0;
            need_q    <= '0;
            hidx_q    <= '0;
            src_rd_q  <= '0;
            dat_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        chan_q   <= hit_ch;
                        src_rd_q <= NCHAN'(1) << hit_ch;
                        state_q  <= POP_HDR;
                    end
                end
                POP_HDR: begin
                    hdr_q   <= head;
                    state_q <= POP_NW;
                end
                POP_NW: begin
                    nw_q      <= head;
                    rem_q     <= head;
                    burst_q   <= '0;
                    src_rd_q  <= '0;
                    hidx_q    <= (TAG_EN != 0) ? 3'd0 : 3'd1;
                    dat_q     <= (TAG_EN != 0) ? tag : hdr_q[15:8];
                    pending_q <= !event_pause_i;
                    state_q   <= HDR_OUT;
                end
                HDR_OUT: begin
                    if (consume && hidx_q == 3'd4) begin
                        pending_q <= 1'b0;
                        if (nw_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CHECK;
                        end
                    end else if (consume) begin
                        hidx_q    <= hidx_q + 3'd1;
                        dat_q     <= hnext;
                        pending_q <= !event_pause_i;
                    end else begin
                        pending_q <= !event_pause_i;
                    end
                end
                CHECK: begin
                    if (32'(rem_q) < 32'(BURST_WORDS)) need_q <= rem_q;
                    else need_q <= 16'(BURST_WORDS);
                    state_q <= CHK_WAIT;
                end
                CHK_WAIT: begin
                    if (32'(cnt) >= 32'(need_q) && !event_pause_i) begin
                        dat_q     <= head[15:8];
                        pending_q <= 1'b1;
                        state_q   <= SEND_MSB;
                    end
                end
                SEND_MSB: begin
                    if (consume) begin
                        dat_q   <= head[7:0];
                        state_q <= SEND_LSB;
                    end else if (event_pause_i) begin
                        pending_q <= 1'b0;
                        burst_q   <= '0;
                        state_q   <= CHECK;
                    end
                end
                SEND_LSB: begin
                    if (consume) begin
                        pending_q <= 1'b0;
                        src_rd_q  <= NCHAN'(1) << chan_q;
                        rem_q     <= rem_q - 16'd1;
                        burst_q   <= burst_q + 16'd1;
                        state_q   <= SEND_POP;
                    end
                end
                SEND_POP: begin
                    src_rd_q <= '0;
                    if (rem_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (burst_q == need_q || event_pause_i) begin
                        burst_q <= '0;
                        state_q <= CHECK;
                    end else begin
                        state_q <= SEND_LOAD;
                    end
                end
                // Head word has advanced past the pop; present its MSB.
                SEND_LOAD: begin
                    dat_q     <= head[15:8];
                    pending_q <= 1'b1;
                    state_q   <= SEND_MSB;
                end
                DONE: begin
                    rr_q    <= (chan_q == 3'(NCHAN - 1)) ? 3'd0 : chan_q + 3'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_rd_o        = src_rd_q;
    assign bridge_dat_o    = dat_q;
    assign event_pending_o = pending_q;
    assign event_done_o    = done_q;
    assign chan_o          = chan_q;

endmodule

// File: tb/tb_atriusb_event_readout_mux.sv
// Bench for atriusb_event_readout_mux: two instances (tagged/burst 4,
// untagged/burst 256) fed by FWFT FIFO models, bytes collected at the bridge.
module tb_atriusb_event_readout_mux;

    localparam int NC = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [16*NC-1:0] sdat [2];
    logic [CW*NC-1:0] scnt [2];
    logic [NC-1:0]    srd  [2];
    logic [7:0]       bdat [2];
    logic             brd  [2];
    logic             pause[2];
    logic             pend [2];
    logic             done [2];
    logic [2:0]       chan [2];

    atriusb_event_readout_mux #(
        .NCHAN(NC), .CNT_W(CW), .BURST_WORDS(4), .TAG_EN(1)
    ) u_dut0 (
        .phy_clk_i(clk), .rst_i(rst),
        .src_dat_i(sdat[0]), .src_count_i(scnt[0]), .src_rd_o(srd[0]),
        .bridge_dat_o(bdat[0]), .bridge_rd_i(brd[0]),
        .event_pause_i(pause[0]), .event_pending_o(pend[0]),
        .event_done_o(done[0]), .chan_o(chan[0])
    );

    atriusb_event_readout_mux #(
        .NCHAN(NC), .CNT_W(CW), .BURST_WORDS(256), .TAG_EN(0)
    ) u_dut1 (
        .phy_clk_i(clk), .rst_i(rst),
        .src_dat_i(sdat[1]), .src_count_i(scnt[1]), .src_rd_o(srd[1]),
        .bridge_dat_o(bdat[1]), .bridge_rd_i(brd[1]),
        .event_pause_i(pause[1]), .event_pending_o(pend[1]),
        .event_done_o(done[1]), .chan_o(chan[1])
    );

    // FIFO models: count and head follow the read pointer after each pop edge.
    logic [15:0] mem [2][NC][64];
    int wp [2][NC];
    int rp [2][NC];
    logic [7:0] rx [2][1024];
    int rxn [2];
    int donecnt [2];
    int popcnt [2];
    int underflow;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                sdat[d][16*c +: 16] = mem[d][c][rp[d][c] & 63];
                scnt[d][CW*c +: CW] = CW'(wp[d][c] - rp[d][c]);
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (brd[d] && pend[d]) begin
                rx[d][rxn[d] & 1023] <= bdat[d];
                rxn[d] <= rxn[d] + 1;
            end
            if (done[d]) donecnt[d] <= donecnt[d] + 1;
            popcnt[d] <= popcnt[d] + $countones(srd[d]);
            for (int c = 0; c < NC; c++) begin
                if (srd[d][c]) begin
                    if (wp[d][c] == rp[d][c]) underflow <= underflow + 1;
                    else rp[d][c] <= rp[d][c] + 1;
                end
            end
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input int c, input logic [15:0] w);
        mem[d][c][wp[d][c] & 63] = w;
        wp[d][c] = wp[d][c] + 1;
    endtask

    task automatic flush();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++) wp[d][c] = rp[d][c];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        flush();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int d, input int target, input string nm);
        for (int k = 0; k < 400 && donecnt[d] < target; k++) @(negedge clk);
        check({nm, "_done"}, 32'(donecnt[d] >= target), 32'd1);
    endtask

    task automatic wait_rx(input int d, input int target, input string nm);
        for (int k = 0; k < 400 && rxn[d] < target; k++) @(negedge clk);
        check({nm, "_rx"}, 32'(rxn[d] >= target), 32'd1);
    endtask

    task automatic check_bytes(input int d, input int base,
                               input logic [127:0] e, input int n,
                               input string nm);
        for (int j = 0; j < n; j++)
            check($sformatf("%s_b%0d", nm, j), 32'(rx[d][(base + j) & 1023]),
                  32'(e[8*(n-1-j) +: 8]));
    endtask

    typedef struct {
        int          d;
        int          ch;
        logic [15:0] hdr;
        int          n;
        logic [15:0] pay [3];
        int          elen;
        logic [127:0] exp;
    } vec_t;

    vec_t tv [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int base, dn, pp;
        tv[0] = '{0, 2, 16'hA55A, 2, '{16'h1234, 16'h5678, 16'h0}, 9,
                  128'h02A55A000212345678};
        tv[1] = '{0, 1, 16'h0F0F, 0, '{16'h0, 16'h0, 16'h0}, 5,
                  128'h010F0F0000};
        tv[2] = '{1, 0, 16'h1234, 0, '{16'h0, 16'h0, 16'h0}, 4,
                  128'h12340000};
        tv[3] = '{1, 3, 16'hBEEF, 1, '{16'h00FF, 16'h0, 16'h0}, 6,
                  128'hBEEF000100FF};
        tv[4] = '{0, 0, 16'hFFFF, 3, '{16'h0001, 16'h8000, 16'h7E7E}, 11,
                  128'h00FFFF0003000180007E7E};
        tv[5] = '{0, 3, 16'h8001, 1, '{16'hCAFE, 16'h0, 16'h0}, 7,
                  128'h0380010001CAFE};

        brd[0] = 1'b1; brd[1] = 1'b1;
        pause[0] = 1'b0; pause[1] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d_rd", d), 32'(srd[d]), 32'd0);
            check($sformatf("rst%0d_dat", d), 32'(bdat[d]), 32'd0);
            check($sformatf("rst%0d_pend", d), 32'(pend[d]), 32'd0);
            check($sformatf("rst%0d_done", d), 32'(done[d]), 32'd0);
            check($sformatf("rst%0d_chan", d), 32'(chan[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            int d;
            d = tv[i].d;
            base = rxn[d]; dn = donecnt[d]; pp = popcnt[d];
            push(d, tv[i].ch, tv[i].hdr);
            push(d, tv[i].ch, 16'(tv[i].n));
            for (int k = 0; k < tv[i].n; k++) push(d, tv[i].ch, tv[i].pay[k]);
            wait_done(d, dn + 1, $sformatf("v%0d", i));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_len", i), 32'(rxn[d] - base), 32'(tv[i].elen));
            check_bytes(d, base, tv[i].exp, tv[i].elen, $sformatf("v%0d", i));
            check($sformatf("v%0d_chan", i), 32'(chan[d]), 32'(tv[i].ch));
            check($sformatf("v%0d_pops", i), 32'(popcnt[d] - pp), 32'(2 + tv[i].n));
            check($sformatf("v%0d_ndone", i), 32'(donecnt[d] - dn), 32'd1);
            check($sformatf("v%0d_pend", i), 32'(pend[0]), 32'd0);
        end

        // Burst gating: N=10 with only 6 payload words resident.
        base = rxn[0]; dn = donecnt[0]; pp = popcnt[0];
        push(0, 1, 16'hB000);
        push(0, 1, 16'd10);
        for (int k = 0; k < 6; k++) push(0, 1, 16'h0A00 + 16'(k));
        wait_rx(0, base + 13, "burst1");
        repeat (6) @(negedge clk);
        check("burst1_len", 32'(rxn[0] - base), 32'd13);
        check("burst1_pend", 32'(pend[0]), 32'd0);
        check("burst1_pops", 32'(popcnt[0] - pp), 32'd6);
        push(0, 1, 16'h0A06);
        push(0, 1, 16'h0A07);
        wait_rx(0, base + 21, "burst2");
        repeat (6) @(negedge clk);
        check("burst2_len", 32'(rxn[0] - base), 32'd21);
        check("burst2_pend", 32'(pend[0]), 32'd0);
        push(0, 1, 16'h0A08);
        push(0, 1, 16'h0A09);
        wait_done(0, dn + 1, "burst3");
        repeat (2) @(negedge clk);
        check("burst3_len", 32'(rxn[0] - base), 32'd25);
        check_bytes(0, base, 128'h01B000000A, 5, "bursthdr");
        for (int k = 0; k < 10; k++) begin
            check($sformatf("burstp%0d_hi", k), 32'(rx[0][(base+5+2*k) & 1023]), 32'h0A);
            check($sformatf("burstp%0d_lo", k), 32'(rx[0][(base+6+2*k) & 1023]), 32'(k));
        end

        // Pause right after a payload MSB is consumed.
        base = rxn[0]; dn = donecnt[0];
        push(0, 0, 16'h5A5A);
        push(0, 0, 16'd2);
        push(0, 0, 16'hC0DE);
        push(0, 0, 16'hBEEF);
        wait_rx(0, base + 6, "pause_msb");
        pause[0] = 1'b1;
        repeat (3) @(negedge clk);
        pp = popcnt[0];
        repeat (10) @(negedge clk);
        check("pause_len", 32'(rxn[0] - base), 32'd7);
        check("pause_pend", 32'(pend[0]), 32'd0);
        check("pause_pops", 32'(popcnt[0] - pp), 32'd0);
        pause[0] = 1'b0;
        wait_done(0, dn + 1, "pause_rel");
        repeat (2) @(negedge clk);
        check("pause_tot", 32'(rxn[0] - base), 32'd9);
        check_bytes(0, base, 128'h005A5A0002C0DEBEEF, 9, "pause");

        // Reset in the middle of a payload.
        base = rxn[0];
        push(0, 2, 16'h9999);
        push(0, 2, 16'd3);
        push(0, 2, 16'h1111);
        push(0, 2, 16'h2222);
        push(0, 2, 16'h3333);
        wait_rx(0, base + 7, "mid");
        rst = 1'b1;
        @(negedge clk);
        flush();
        check("mid_rd", 32'(srd[0]), 32'd0);
        check("mid_dat", 32'(bdat[0]), 32'd0);
        check("mid_pend", 32'(pend[0]), 32'd0);
        check("mid_done", 32'(done[0]), 32'd0);
        check("mid_chan", 32'(chan[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        base = rxn[0]; dn = donecnt[0];
        push(0, 1, 16'h7777);
        push(0, 1, 16'd1);
        push(0, 1, 16'h4242);
        wait_done(0, dn + 1, "post");
        repeat (2) @(negedge clk);
        check("post_len", 32'(rxn[0] - base), 32'd7);
        check_bytes(0, base, 128'h0177770001_4242, 7, "post");

        // Round robin from a freshly reset pointer.
        do_reset();
        @(negedge clk);
        base = rxn[0]; dn = donecnt[0];
        push(0, 3, 16'h3333); push(0, 3, 16'd1); push(0, 3, 16'hBBBB);
        push(0, 0, 16'h1111); push(0, 0, 16'd1); push(0, 0, 16'hAAAA);
        wait_done(0, dn + 2, "rr");
        repeat (2) @(negedge clk);
        check("rr_len", 32'(rxn[0] - base), 32'd14);
        check_bytes(0, base, 128'h0011110001AAAA0333330001BBBB, 14, "rr");
        check("rr_chan", 32'(chan[0]), 32'd3);
        base = rxn[0]; dn = donecnt[0];
        push(0, 2, 16'h2222); push(0, 2, 16'd0);
        push(0, 1, 16'h5555); push(0, 1, 16'd0);
        wait_done(0, dn + 2, "rr2");
        repeat (2) @(negedge clk);
        check_bytes(0, base, 128'h01555500000222220000, 10, "rr2");

        check("underflow", 32'(underflow), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/atriusb_event_readout_mux.md
Name: atriusb_event_readout_mux

Overview:
- Parametrised successor to the single-FIFO USB event readout.
- Drains NCHAN per-source event FIFOs into one byte-wide FX2 bridge stream. Sources are first-word-fall-through, 16-bit, with a word count.
- Arbitrates round-robin per event, optionally prefixes a channel tag byte, and only offers data to the bridge when a full burst (or the event remainder) is resident.
- Sits between the per-daughterboard event FIFOs and the FX2 bridge, in the PHY clock domain.

Parameters:
- NCHAN, 4: number of source FIFOs, 1..8.
- CNT_W, 16: width of each source word count.
- BURST_WORDS, 256: maximum words sent per pending window; power of 2, at most 2^CNT_W-1.
- TAG_EN, 1: 1 prefixes each event with byte {5'b0, chan[2:0]}; 0 omits it.

Ports:
- phy_clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- src_dat_i  in  16*NCHAN  FWFT head word per source; channel c occupies [16c+:16].
- src_count_i  in  CNT_W*NCHAN  words resident per source.
- src_rd_o  out  NCHAN  pop strobe per source; at most one bit high.
- bridge_dat_o  out  8  current byte.
- bridge_rd_i  in  1  bridge consumes bridge_dat_o this cycle.
- event_pause_i  in  1  stop offering data at the next byte boundary.
- event_pending_o  out  1  bridge_dat_o is valid and may be consumed.
- event_done_o  out  1  one-cycle pulse after the last byte of an event.
- chan_o  out  3  channel being served.

Behaviour:
- Reset (sync, any state): state=IDLE, rr pointer=0.
  - All outputs 0: src_rd_o=0, bridge_dat_o=0, event_pending_o=0, event_done_o=0, chan_o=0.
  - A partially sent event is abandoned. Upstream FIFOs are reset by their owners.
- Event format from source: word0 header, word1 nwords (N), then N payload words.
- Byte order on the bridge: [tag], hdr[15:8], hdr[7:0], N[15:8], N[7:0], then each payload word MSB first. Total 4+2N(+1) bytes.
- States:
  - IDLE: search channels starting at the rr pointer, wrapping, for the first with count>=2. On a hit, latch chan_o and go to POP_HDR.
  - POP_HDR: src_rd_o[chan]=1; latch header. Next state POP_NW.
  - POP_NW: src_rd_o[chan]=1; latch N; remaining=N; burst=0. Next state HDR_OUT.
  - HDR_OUT: offer the tag/header/N bytes with pending=1 unless event_pause_i. When the last header byte is consumed: go to CHECK if N>0, else DONE.
  - CHECK: compute need = min(remaining, BURST_WORDS); registered, so it takes 1 cycle. When count>=need and !event_pause_i, go to SEND.
  - SEND: pending=1; bridge_dat_o = MSB, then LSB, of the head word.
    - On consuming the LSB: pulse src_rd_o, remaining-1, burst+1.
    - When remaining reaches 0, go to DONE.
    - Else, when burst reaches BURST_WORDS or event_pause_i is seen at a word boundary, pending=0 and go to CHECK with burst=0.
  - DONE: event_done_o=1 for 1 cycle; rr pointer = chan+1 mod NCHAN; back to IDLE.
- Handshake:
  - The byte on bridge_dat_o is consumed only when bridge_rd_i && event_pending_o. The next byte is valid the following cycle (one byte per cycle maximum).
  - bridge_rd_i while pending=0 is ignored.
- Pause:
  - Never splits a word in SEND. The MSB has been consumed, so the LSB is still offered.
  - In HDR_OUT, pending drops until the pause is released.
- src_rd_o is never asserted when the selected count is 0. Count decrements from the source are visible 1 cycle after the pop; CHECK accounts for this.
- Count arithmetic: unsigned CNT_W bits; remaining is 16 bits; N=0xFFFF is supported.
- Arbitration: if no channel qualifies, stay in IDLE. Simultaneous ready channels are served in rr order.

Test Plan:
- Single channel, NCHAN=4, TAG_EN=1: ch2 holds {0xA55A, 2, 0x1234, 0x5678}, bridge_rd_i held high -> bytes 02 A5 5A 00 02 12 34 56 78; event_done_o pulses once; chan_o=2.
- Round robin: ch0 and ch3 each hold one N=1 event, pointer=0 -> ch0 event fully sent, then ch3; next search starts at 0.
- Burst gating, BURST_WORDS=4, N=10, count=6 after header -> 4 words sent; pending drops; waits in CHECK until count>=4; then 4 words; then the final 2 once count>=2.
- Pause: event_pause_i asserted after a payload MSB is consumed -> LSB still offered and consumed; pending=0 until release; no src_rd_o while paused.
- N=0 event with TAG_EN=0 -> exactly 4 bytes, then event_done_o; no payload pops.
- rst_i mid-SEND -> next cycle all outputs 0, state IDLE, rr pointer 0; a subsequent event on ch1 is read out from its header.
